cordic_sm_iter_engine: RTL and testbench

Parametrised, self-sequencing CORDIC X/Y iteration engine in sign-magnitude arithmetic, with one shared add/subtract datapath time-multiplexed between Y and X updates. Each run loads arbitrary X0/Y0, executes N_ITER micro-rotations, and reports completion with a done pulse. It supports rotation mode, where the direction comes from the external Z path, and vectoring mode, where the direction comes from the sign of Y. It sits between the Z-angle path and the output normaliser of the CORDIC core.

---
 rtl/cordic_sm_iter_engine.sv | 181 ++++++++++++++++++
 tb/tb_cordic_sm_iter_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sm_iter_engine.sv
// CORDIC X/Y micro-rotation engine, sign-magnitude datapath.
// One shared adder alternates between the Y and X updates.
module cordic_sm_iter_engine #(
  parameter int W      = 24,
  parameter int N_ITER = 16,
  parameter int IW     = 5
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iStart,
  input  logic          iMode,
  input  logic [W:0]    iX0,
  input  logic [W:0]    iY0,
  input  logic          iDir,
  input  logic          iAbort,
  output logic [W:0]    oX,
  output logic [W:0]    oY,
  output logic [IW-1:0] oIter,
  output logic          oDir,
  output logic          oBusy,
  output logic          oDone,
  output logic          oOvf
);

  typedef enum logic [1:0] {
    IDLE,
    PH_Y,
    PH_X,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    x_q, x_d;
  logic [W:0]    y_q, y_d;
  logic [W:0]    yo_q, yo_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic          ovf_q, ovf_d;

  logic          dir_now;
  logic [W:0]    op_a;
  logic [W:0]    op_b;
  logic [W+1:0]  sum;

  function automatic logic [W-1:0] shr(
    input logic [W-1:0]  m,
    input logic [IW-1:0] s
  );
    if (32'(s) >= 32'(W)) return '0;
    return m >> s;
  endfunction

  // Result is {saturated, sign, magnitude}.
  function automatic logic [W+1:0] sm_add(
    input logic [W:0] a,
    input logic [W:0] b
  );
    logic [W:0]   t;
    logic [W-1:0] m;
    logic         s;
    logic         o;
    o = 1'b0;
    if (a[W] == b[W]) begin
      t = {1'b0, a[W-1:0]} + {1'b0, b[W-1:0]};
      s = a[W];
      if (t[W]) begin
        m = '1;
        o = 1'b1;
      end else begin
        m = t[W-1:0];
      end
    end else begin
      t = {1'b0, a[W-1:0]} - {1'b0, b[W-1:0]};
      if (t[W]) begin
        m = -t[W-1:0];
        s = b[W];
      end else begin
        m = t[W-1:0];
        s = a[W];
      end
    end
    if (m == '0) s = 1'b0;
    return {o, s, m};
  endfunction

  // dir = 1 means d = -1.
  assign dir_now = mode_q ? ~y_q[W] : iDir;

  always_comb begin
    op_a = y_q;
    op_b = {x_q[W] ^ dir_now, shr(x_q[W-1:0], iter_q)};
    if (state_q == PH_X) begin
      op_a = x_q;
      op_b = {yo_q[W] ^ ~dir_q, shr(yo_q[W-1:0], iter_q)};
    end
  end

  assign sum = sm_add(op_a, op_b);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    yo_d    = yo_q;
    iter_d  = iter_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          x_d     = iX0;
          y_d     = iY0;
          mode_d  = iMode;
          iter_d  = '0;
          ovf_d   = 1'b0;
          state_d = PH_Y;
        end
      end
      PH_Y: begin
        if (iAbort) begin
          state_d = IDLE;
        end else begin
          dir_d   = dir_now;
          yo_d    = y_q;
          y_d     = sum[W:0];
          ovf_d   = ovf_q | sum[W+1];
          state_d = PH_X;
        end
      end
      PH_X: begin
        if (iAbort) begin
          state_d = IDLE;
        end else begin
          x_d   = sum[W:0];
          ovf_d = ovf_q | sum[W+1];
          if (iter_q == IW'(N_ITER - 1)) begin
            state_d = DONE;
          end else begin
            iter_d  = iter_q + 1'b1;
            state_d = PH_Y;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      yo_q    <= '0;
      iter_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      yo_q    <= yo_d;
      iter_q  <= iter_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oX    = x_q;
  assign oY    = y_q;
  assign oIter = iter_q;
  assign oDir  = (state_q == PH_Y) ? dir_now : dir_q;
  assign oBusy = (state_q != IDLE);
  assign oDone = (state_q == DONE);
  assign oOvf  = ovf_q;

endmodule

// File: tb/tb_cordic_sm_iter_engine.sv
// Bench for cordic_sm_iter_engine: one N_ITER=1 and one N_ITER=16
// instance, scoreboard queues checked by oDone monitors.
module tb_cordic_sm_iter_engine;
  localparam int W  = 24;
  localparam int IW = 5;
  localparam longint MAXM = (64'd1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start1, start16, mode, dir, abort;
  logic [W:0]    x0, y0;
  logic [W:0]    x1, y1, x16, y16;
  logic [IW-1:0] it1, it16;
  logic          dir1, busy1, done1, ovf1;
  logic          dir16, busy16, done16, ovf16;

  cordic_sm_iter_engine #(.W(W), .N_ITER(1), .IW(IW)) u1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start1), .iMode(mode),
    .iX0(x0), .iY0(y0), .iDir(dir), .iAbort(abort),
    .oX(x1), .oY(y1), .oIter(it1), .oDir(dir1),
    .oBusy(busy1), .oDone(done1), .oOvf(ovf1)
  );

  cordic_sm_iter_engine #(.W(W), .N_ITER(16), .IW(IW)) u16 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start16), .iMode(mode),
    .iX0(x0), .iY0(y0), .iDir(dir), .iAbort(abort),
    .oX(x16), .oY(y16), .oIter(it16), .oDir(dir16),
    .oBusy(busy16), .oDone(done16), .oOvf(ovf16)
  );

  typedef struct packed {
    logic [W:0] x;
    logic [W:0] y;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q16[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic unexp(string name);
    checks++;
    errors++;
    $display("FAIL %s: oDone with no expected result", name);
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) unexp("u1_done");
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_sb_x", x1, e.x);
        chk("u1_sb_y", y1, e.y);
        chk("u1_sb_ovf", ovf1, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) unexp("u16_done");
      else begin
        exp_t e;
        e = q16.pop_front();
        chk("u16_sb_x", x16, e.x);
        chk("u16_sb_y", y16, e.y);
        chk("u16_sb_ovf", ovf16, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] sm(bit s, logic [W-1:0] m);
    return {s, m};
  endfunction

  function automatic longint sm2l(logic [W:0] v);
    longint m;
    m = longint'(v[W-1:0]);
    return v[W] ? -m : m;
  endfunction

  function automatic logic [W:0] l2sm(longint v);
    longint a;
    a = (v < 0) ? -v : v;
    return {(v < 0), a[W-1:0]};
  endfunction

  function automatic longint shr_v(longint v, int i);
    longint m;
    m = (v < 0) ? -v : v;
    m = (i >= W) ? 0 : (m >> i);
    return (v < 0) ? -m : m;
  endfunction

  // Rotation-mode reference; alt selects d=-1 on odd iterations.
  task automatic model(input logic [W:0] xi, input logic [W:0] yi,
                       input int n, input bit alt,
                       output logic [W:0] xo, output logic [W:0] yo,
                       output bit ov);
    longint x, y, yold, t;
    ov = 0;
    x = sm2l(xi);
    y = sm2l(yi);
    for (int i = 0; i < n; i++) begin
      bit dn;
      dn = alt && i[0];
      yold = y;
      t = shr_v(x, i);
      y = y + (dn ? -t : t);
      if (y > MAXM) begin y = MAXM; ov = 1; end
      if (y < -MAXM) begin y = -MAXM; ov = 1; end
      t = shr_v(yold, i);
      x = x - (dn ? -t : t);
      if (x > MAXM) begin x = MAXM; ov = 1; end
      if (x < -MAXM) begin x = -MAXM; ov = 1; end
    end
    xo = l2sm(x);
    yo = l2sm(y);
  endtask

  task automatic run1(string tag, logic [W:0] xi, logic [W:0] yi,
                      logic m, logic d, logic [W:0] ex,
                      logic [W:0] ey, logic eo, logic edir);
    q1.push_back('{ex, ey, eo});
    x0 = xi; y0 = yi; mode = m; dir = d;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk({tag, "_ovf_clr"}, ovf1, 0);
    chk({tag, "_busy"}, busy1, 1);
    tick();
    chk({tag, "_dir"}, dir1, edir);
    chk({tag, "_y_early"}, y1, ey);
    tick();
    chk({tag, "_done_c3"}, done1, 1);
    tick();
    chk({tag, "_idle"}, {busy1, done1}, 2'b00);
    chk({tag, "_ovf_hold"}, ovf1, eo);
  endtask

  initial begin
    logic [W:0] ex, ey;
    bit eo;
    rst_n = 0; start1 = 0; start16 = 0;
    mode = 0; dir = 0; abort = 0; x0 = '0; y0 = '0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_u1", {x1, y1, it1, dir1, busy1, done1, ovf1}, 0);
    chk("rst_u16", {x16, y16, it16, dir16, busy16, done16, ovf16}, 0);

    run1("rot", sm(0, 24'h400000), sm(0, 24'h200000), 0, 0,
         sm(0, 24'h200000), sm(0, 24'h600000), 0, 0);
    run1("rotneg", sm(0, 24'h400000), sm(0, 24'h200000), 0, 1,
         sm(0, 24'h600000), sm(1, 24'h200000), 0, 1);
    run1("flip", sm(0, 24'h100000), sm(0, 24'h300000), 0, 0,
         sm(1, 24'h200000), sm(0, 24'h400000), 0, 0);
    run1("nozero", sm(0, 24'h200000), sm(0, 24'h200000), 0, 0,
         sm(0, 24'h000000), sm(0, 24'h400000), 0, 0);
    run1("vec_neg", sm(0, 24'h400000), sm(1, 24'h100000), 1, 1,
         sm(0, 24'h500000), sm(0, 24'h300000), 0, 0);
    run1("vec_pos", sm(0, 24'h400000), sm(0, 24'h100000), 1, 0,
         sm(0, 24'h500000), sm(1, 24'h300000), 0, 1);
    run1("ovf", sm(0, 24'hC00000), sm(0, 24'hC00000), 0, 0,
         sm(0, 24'h000000), sm(0, 24'hFFFFFF), 1, 0);
    run1("ovf_clr", sm(0, 24'h400000), sm(0, 24'h200000), 0, 0,
         sm(0, 24'h200000), sm(0, 24'h600000), 0, 0);

    // 16 iterations, direction alternating, stray start at cycle 10
    model(sm(0, 24'h300000), sm(1, 24'h123456), 16, 1, ex, ey, eo);
    q16.push_back('{ex, ey, eo});
    x0 = sm(0, 24'h300000); y0 = sm(1, 24'h123456); mode = 0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      dir = k[0];
      chk("seq_iter", it16, k);
      tick();
      chk("seq_dir", dir16, k[0]);
      chk("seq_nodone", done16, 0);
      if (2 * k + 2 == 10) start16 = 1'b1;
      tick();
      start16 = 1'b0;
    end
    chk("seq_done_c33", done16, 1);
    tick();
    chk("seq_idle_c34", {busy16, done16}, 2'b00);
    dir = 0;

    // abort during PH_Y of iteration 3 (cycle 7)
    model(sm(0, 24'h280000), sm(0, 24'h0A0000), 3, 0, ex, ey, eo);
    x0 = sm(0, 24'h280000); y0 = sm(0, 24'h0A0000);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_c8", busy16, 0);
    chk("abort_x", x16, ex);
    chk("abort_y", y16, ey);
    repeat (40) tick();
    chk("abort_x_hold", x16, ex);
    chk("abort_y_hold", y16, ey);

    // synchronous reset at cycle 5
    x0 = sm(0, 24'h355555); y0 = sm(1, 24'h111111);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid", {x16, y16, it16, dir16, busy16, done16, ovf16}, 0);
    rst_n = 1'b1;
    repeat (40) tick();

    chk("sb_empty", q1.size() + q16.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
